// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output PWM / static drive stage fed by SPI control registers
//
// Purpose:
//   Drives 16 user outputs, each one forced low, forced high, or following a
//   shared PWM waveform. A prescaler divides clk by CLK_DIV to step an 8-bit
//   period counter; one PWM period is CLK_DIV*256 clks. The duty cycle is
//   captured into a shadow register only at the period wrap, so software
//   writes never produce a truncated or stretched pulse.
//
// Ports:
//   clk             - system clock, rising edge
//   rst_n           - synchronous active-low reset
//   en_reg_out_7_0  - output enables, bits 7:0
//   en_reg_out_15_8 - output enables, bits 15:8
//   en_reg_pwm_7_0  - PWM mode select, bits 7:0
//   en_reg_pwm_15_8 - PWM mode select, bits 15:8
//   pwm_duty_cycle  - duty, 0x00 = 0%, 0xFF = 100%
//   out             - registered user outputs
//   period_start    - one-clk pulse on the first clk of each PWM period

module pwm_peripheral #(
  parameter int CLK_DIV = 13,
  parameter int PRESC_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         duty_sh_q, duty_sh_d;
  logic [15:0]        out_q, out_d;
  logic               period_start_q, period_start_d;
  // High only while in reset; lets the first clk after release raise
  // period_start, since the restart from 0 is not signalled by a wrap.
  logic               restart_q;

  logic        tick;
  logic        wrap;
  logic        pwm_raw;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (cnt_q == 8'hFF);

  // 0xFF is special-cased so the output stays high through cnt = 255
  // instead of dropping for one counter step.
  assign pwm_raw = (duty_sh_q == 8'hFF) || (cnt_q < duty_sh_q);

  always_comb begin
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    duty_sh_d      = duty_sh_q;
    out_d          = out_q;
    period_start_d = 1'b0;

    if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + 8'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    if (wrap) begin
      duty_sh_d = pwm_duty_cycle;
    end

    period_start_d = wrap || restart_q;

    // Disabled -> 0; enabled static -> 1; enabled PWM -> shared waveform.
    out_d = en_out & (~en_pwm | {16{pwm_raw}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= 8'h00;
      duty_sh_q      <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
      restart_q      <= 1'b1;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
      restart_q      <= 1'b0;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed self-checking bench for pwm_peripheral

module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int n_checks = 0;
  int n_fail   = 0;

  int   len, high;
  logic first;
  int   bad_hi, bad_lo;
  logic exp_p;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(13), .PRESC_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps();
    int k = 0;
    while (!period_start && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!period_start) check("wait_ps_timeout", 0, 1);
  endtask

  // Starts at a negedge where period_start is high. Counts the samples up to and
  // including the next period_start; since out lags cnt by one clk, samples 1..N
  // show exactly the waveform of the period that began here.
  task automatic measure(input int chg_at, input logic [7:0] chg_val,
                         output int n, output int hi, output logic s1);
    n  = 0;
    hi = 0;
    s1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) s1 = out[0];
      if (out[0]) hi++;
      if (n == chg_at) duty = chg_val;
    end while (!period_start && n < 4000);
    if (!period_start) check("measure_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    duty  = 8'h80;
    set_en(16'hFFFF, 16'hFFFF);

    // Reset held 5 clks with everything enabled
    repeat (5) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_ps", period_start, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ps", period_start, 1);
    check("release_out", out, 0);

    // First period after reset runs with duty 0; release edge already advanced presc
    measure(-1, 8'h00, len, high, first);
    check("first_period_high", high, 0);
    check("first_period_len", len, 3327);

    // 50% duty, shadow loaded with 0x80 at the previous wrap
    check("p50_low_at_ps", out[0], 0);
    measure(-1, 8'h00, len, high, first);
    check("p50_len", len, 3328);
    check("p50_high", high, 1664);
    check("p50_rise_after_ps", first, 1);

    // Static modes
    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    check("static_all_on", out, 16'hFFFF);
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    check("static_00f0", out, 16'h00F0);

    // Duty 0x00
    set_en(16'h0001, 16'h0001);
    duty = 8'h00;
    wait_ps();
    measure(-1, 8'h00, len, high, first);
    check("duty00_len", len, 3328);
    check("duty00_high", high, 0);

    // Duty 0x01: one period to load, then measure
    duty = 8'h01;
    measure(-1, 8'h00, len, high, first);
    measure(-1, 8'h00, len, high, first);
    check("duty01_high", high, 13);

    // Duty 0xFF: the last sample covers cnt = 255, so full count means no dip at the wrap
    duty = 8'hFF;
    measure(-1, 8'h00, len, high, first);
    measure(-1, 8'h00, len, high, first);
    check("dutyFF_high", high, 3328);
    check("dutyFF_at_wrap", out[0], 1);

    // Double buffering: 0x40 period, duty rewritten to 0xC0 at cnt = 0x20 (416 clks in)
    duty = 8'h40;
    measure(-1, 8'h00, len, high, first);
    measure(416, 8'hC0, len, high, first);
    check("dbuf_current_high", high, 832);
    measure(-1, 8'h00, len, high, first);
    check("dbuf_next_high", high, 2496);

    // Mixed bits, 50% duty, then reset at cnt = 100
    set_en(16'hA5A5, 16'h00FF);
    duty = 8'h80;
    measure(-1, 8'h00, len, high, first);
    bad_hi = 0;
    bad_lo = 0;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      exp_p = ((i - 1) / 13) < 128;
      if (out[15:8] != 8'hA5) bad_hi++;
      if (out[7:0] != (exp_p ? 8'hA5 : 8'h00)) bad_lo++;
    end
    check("mixed_static_hi_errs", bad_hi, 0);
    check("mixed_pwm_lo_errs", bad_lo, 0);

    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out", out, 0);
    check("midrst_ps", period_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ps", period_start, 1);
    check("midrst_release_out", out, 16'hA500);
    measure(-1, 8'h00, len, high, first);
    check("midrst_restart_len", len, 3327);
    check("midrst_duty0_high", high, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
